ov_write: RTL and testbench
===========================

OV_WRITE -- requirements
Module: ov_write

Interface
REQ-001 SHALL have parameter WRST_CYCLES, default 16, number of clk_24MHz cycles wrst is held low per frame.
REQ-002 SHALL have parameter FRAME_LINES, default 240, expected HREF lines per frame.
REQ-003 SHALL have clk_24MHz  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have initialized  input  1  camera register setup complete; high enables operation.
REQ-006 SHALL have vsync  input  1  camera VSYNC, asynchronous to clk_24MHz, high during vertical blanking.
REQ-007 SHALL have href  input  1  camera HREF, asynchronous, high during active line.
REQ-008 SHALL have frame_read  input  1  reader idle flag; low while the reader drains the FIFO, high when done.
REQ-009 SHALL have wen  output  1  FIFO write enable, active-high (board gates it with HREF).
REQ-010 SHALL have wrst  output  1  FIFO write-pointer reset, active-low.
REQ-011 SHALL have new_frame  output  1  complete frame stored in FIFO, level until acknowledged.
REQ-012 SHALL have frame_error  output  1  last captured frame had a line count other than FRAME_LINES.

Function
REQ-013 SHALL pass vsync and href each through a 2-flop synchronizer; edges detected on synchronized copies (edge visible 3 cycles after input change).
REQ-014 SHALL implement states IDLE, WAIT_VS, WRST, WAIT_ACT, CAPTURE, DONE, ACK, READING.
REQ-015 IDLE -> WAIT_VS when initialized=1 and frame_read=1.
REQ-016 WAIT_VS -> WRST on synchronized vsync rising edge; level-high vsync on entry SHALL NOT count as an edge.
REQ-017 WRST: wrst=0 for exactly WRST_CYCLES cycles, then wrst=1, -> WAIT_ACT.
REQ-018 WAIT_ACT -> CAPTURE on synchronized vsync falling edge; wen=1 from the cycle CAPTURE is entered.
REQ-019 CAPTURE -> DONE on next synchronized vsync rising edge; wen=0 in that same cycle.
REQ-020 DONE: new_frame=1, frame_error updated, -> ACK next cycle.
REQ-021 ACK: hold new_frame=1 until frame_read=0, then new_frame=0, -> READING.
REQ-022 READING: wen=0, wrst=1; -> IDLE when frame_read=1.
REQ-023 initialized=0 in any state other than ACK/READING SHALL force wen=0, wrst=1, -> IDLE next cycle; frame_error unchanged.
REQ-024 wen SHALL never be 1 while new_frame=1 or frame_read=0.
REQ-025 vsync edge and href edge in the same cycle SHALL both be processed.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, wen=0, wrst=1, new_frame=0, frame_error=0, line counter 0, synchronizer flops 0.
REQ-027 Reset mid-CAPTURE SHALL discard the frame; no new_frame pulse after release until a full new frame completes.

Configuration
REQ-028 Macro OV_WRITE_LINE_CHECK_EN SHALL control line checking.
REQ-029 With macro: 9-bit counter cleared on entering CAPTURE, incremented on each synchronized href rising edge in CAPTURE, saturating at 511; in DONE frame_error = (count != FRAME_LINES).
REQ-030 Without macro: no counter; href unused; frame_error constant 0.

Verification
REQ-031 rst_n released, initialized=1, frame_read=1, vsync pulse, 240 href pulses, vsync pulse -> wrst low 16 cycles, wen high through frame, new_frame=1, frame_error=0.
REQ-032 Same frame with 239 href pulses (macro defined) -> new_frame=1, frame_error=1; macro undefined -> frame_error=0.
REQ-033 new_frame=1, frame_read driven low after 50 cycles, high after 1000 -> new_frame falls 1 cycle after frame_read low, wen stays 0, no new wrst until frame_read high and next vsync edge.
REQ-034 vsync already high when initialized rises -> no wrst until vsync falls and rises again.
REQ-035 rst_n=0 asserted 100 href lines into CAPTURE -> wen=0, wrst=1, new_frame=0 same cycle; next full frame captured normally.
REQ-036 initialized dropped mid-CAPTURE -> wen=0 next cycle, state IDLE, new_frame stays 0.

Source files
------------

// File: rtl/ov_write.sv
// OV7670 frame capture controller: drives AL422B FIFO wen/wrst from camera VSYNC and handshakes with the reader.
// Optional macro OV_WRITE_LINE_CHECK_EN adds a per-frame HREF line counter that drives frame_error.
module ov_write #(
  parameter int WRST_CYCLES = 16,
  parameter int FRAME_LINES = 240
) (
  input  logic clk_24MHz,
  input  logic rst_n,
  input  logic initialized,
  input  logic vsync,
  input  logic href,
  input  logic frame_read,
  output logic wen,
  output logic wrst,
  output logic new_frame,
  output logic frame_error
);

  localparam int CW = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_VS  = 3'd1;
  localparam logic [2:0] S_WRST     = 3'd2;
  localparam logic [2:0] S_WAIT_ACT = 3'd3;
  localparam logic [2:0] S_CAPTURE  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;
  localparam logic [2:0] S_READING  = 3'd7;

  logic [2:0]    r_state;
  logic [CW-1:0] r_wrst_cnt;
  logic          r_wen;
  logic          r_wrst;
  logic          r_new_frame;
  logic          r_vs_s1;
  logic          r_vs_s2;
  logic          r_vs_d;
  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_abort;

  // Two-flop synchronizer plus one history flop so edges are seen on clean copies only.
  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      r_vs_s1 <= vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
    end
  end

  assign w_vs_rise = r_vs_s2 & ~r_vs_d;
  assign w_vs_fall = ~r_vs_s2 & r_vs_d;

  // Losing camera init aborts everything except a frame the reader already owns.
  assign w_abort = ~initialized && (r_state != S_ACK) && (r_state != S_READING);

  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wrst_cnt  <= '0;
      r_wen       <= 1'b0;
      r_wrst      <= 1'b1;
      r_new_frame <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_wrst  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_read) r_state <= S_WAIT_VS;
        end
        S_WAIT_VS: begin
          if (w_vs_rise) begin
            r_state    <= S_WRST;
            r_wrst     <= 1'b0;
            r_wrst_cnt <= '0;
          end
        end
        S_WRST: begin
          if (r_wrst_cnt == CW'(WRST_CYCLES - 1)) begin
            r_wrst  <= 1'b1;
            r_state <= S_WAIT_ACT;
          end else begin
            r_wrst_cnt <= r_wrst_cnt + 1'b1;
          end
        end
        S_WAIT_ACT: begin
          if (w_vs_fall) begin
            r_state <= S_CAPTURE;
            r_wen   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_vs_rise) begin
            r_state <= S_DONE;
            r_wen   <= 1'b0;
          end
        end
        S_DONE: begin
          r_new_frame <= 1'b1;
          r_state     <= S_ACK;
        end
        S_ACK: begin
          if (!frame_read) begin
            r_new_frame <= 1'b0;
            r_state     <= S_READING;
          end
        end
        S_READING: begin
          r_wen  <= 1'b0;
          r_wrst <= 1'b1;
          if (frame_read) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The output gate keeps the FIFO write port shut whenever the reader owns the buffer.
  assign wen       = r_wen & frame_read & ~r_new_frame;
  assign wrst      = r_wrst;
  assign new_frame = r_new_frame;

`ifdef OV_WRITE_LINE_CHECK_EN
  logic       r_hs_s1;
  logic       r_hs_s2;
  logic       r_hs_d;
  logic [8:0] r_line_cnt;
  logic       r_frame_error;
  logic       w_hs_rise;
  logic       w_enter_capture;
  logic       w_frame_done;

  assign w_hs_rise       = r_hs_s2 & ~r_hs_d;
  assign w_enter_capture = initialized && (r_state == S_WAIT_ACT) && w_vs_fall;
  assign w_frame_done    = initialized && (r_state == S_DONE);

  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_s1       <= 1'b0;
      r_hs_s2       <= 1'b0;
      r_hs_d        <= 1'b0;
      r_line_cnt    <= 9'd0;
      r_frame_error <= 1'b0;
    end else begin
      r_hs_s1 <= href;
      r_hs_s2 <= r_hs_s1;
      r_hs_d  <= r_hs_s2;
      if (w_enter_capture) begin
        r_line_cnt <= 9'd0;
      end else if ((r_state == S_CAPTURE) && w_hs_rise && (r_line_cnt != 9'd511)) begin
        r_line_cnt <= r_line_cnt + 9'd1;
      end
      if (w_frame_done) r_frame_error <= (r_line_cnt != 9'(FRAME_LINES));
    end
  end

  assign frame_error = r_frame_error;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = href | (FRAME_LINES < 0);
  assign frame_error  = 1'b0;
`endif

endmodule

// File: tb/tb_ov_write.sv
// Directed bench for ov_write: table of full frames plus hand-written handshake, reset and abort sequences.
module tb_ov_write;
  localparam int WRST_CYCLES = 16;
  localparam int FRAME_LINES = 240;
`ifdef OV_WRITE_LINE_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  typedef struct {
    int nlines;
    bit coinc;
    bit err_chk;
    int exp_wen;
  } vec_t;

  logic clk;
  logic rst_n, initialized, vsync, href, frame_read;
  logic wen, wrst, new_frame, frame_error;
  int   checks = 0;
  int   errors = 0;
  int   wrst_lo = 0;
  int   wen_hi = 0;
  int   viol = 0;
  vec_t tbl[6];

  ov_write #(.WRST_CYCLES(WRST_CYCLES), .FRAME_LINES(FRAME_LINES)) dut (
    .clk_24MHz  (clk),
    .rst_n      (rst_n),
    .initialized(initialized),
    .vsync      (vsync),
    .href       (href),
    .frame_read (frame_read),
    .wen        (wen),
    .wrst       (wrst),
    .new_frame  (new_frame),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrst === 1'b0) wrst_lo++;
    if (wen === 1'b1) wen_hi++;
    if (wen === 1'b1 && (new_frame !== 1'b0 || frame_read !== 1'b1)) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      href = 1'b1; cyc(4);
      href = 1'b0; cyc(4);
    end
  endtask

  // Opening vsync pulse, then n HREF lines; leaves the DUT in CAPTURE.
  task automatic partial(input int n);
    vsync = 1'b1; cyc(30);
    vsync = 1'b0; cyc(10);
    lines(n);
  endtask

  task automatic frame(input int n, input bit coinc);
    partial(n);
    cyc(6);
    vsync = 1'b1;
    if (coinc) href = 1'b1;
    cyc(4);
    href = 1'b0;
    cyc(26);
    vsync = 1'b0;
    cyc(4);
  endtask

  task automatic wait_nf(input string name);
    int k;
    k = 0;
    while (new_frame !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(name, new_frame, 1);
  endtask

  task automatic handshake(input string name);
    frame_read = 1'b0;
    @(negedge clk);
    chk(name, new_frame, 0);
    cyc(4);
    frame_read = 1'b1;
    cyc(4);
  endtask

  initial begin
    int w0, e0;
    tbl[0] = '{240, 1'b0, 1'b0, 1936};
    tbl[1] = '{239, 1'b0, 1'b1, 1928};
    tbl[2] = '{241, 1'b0, 1'b1, 1944};
    tbl[3] = '{0,   1'b0, 1'b1, 16};
    tbl[4] = '{752, 1'b0, 1'b1, 6032};
    tbl[5] = '{239, 1'b1, 1'b0, 1928};

    rst_n = 1'b0; initialized = 1'b0; frame_read = 1'b1; vsync = 1'b0; href = 1'b0;
    cyc(3);
    chk("rst_wen", wen, 0);
    chk("rst_wrst", wrst, 1);
    chk("rst_new_frame", new_frame, 0);
    chk("rst_frame_error", frame_error, 0);
    rst_n = 1'b1;
    initialized = 1'b1;
    cyc(5);
    chk("idle_wrst", wrst, 1);

    for (int t = 0; t < 6; t++) begin
      w0 = wrst_lo; e0 = wen_hi;
      frame(tbl[t].nlines, tbl[t].coinc);
      wait_nf($sformatf("tbl%0d_new_frame", t));
      chk($sformatf("tbl%0d_wrst_low", t), wrst_lo - w0, WRST_CYCLES);
      chk($sformatf("tbl%0d_wen_cycles", t), wen_hi - e0, tbl[t].exp_wen);
      chk($sformatf("tbl%0d_frame_error", t), frame_error, LCHK ? tbl[t].err_chk : 1'b0);
      chk($sformatf("tbl%0d_wen_idle", t), wen, 0);
      handshake($sformatf("tbl%0d_ack", t));
    end

    // Reader handshake held for a long read; vsync activity must not restart capture.
    frame(240, 1'b0);
    wait_nf("hs_new_frame");
    cyc(50);
    chk("hs_nf_held", new_frame, 1);
    frame_read = 1'b0;
    @(negedge clk);
    chk("hs_nf_fall", new_frame, 0);
    w0 = wrst_lo; e0 = wen_hi;
    vsync = 1'b1; cyc(30);
    vsync = 1'b0; cyc(30);
    vsync = 1'b1; cyc(30);
    vsync = 1'b0;
    cyc(909);
    chk("hs_no_wrst_reading", wrst_lo - w0, 0);
    chk("hs_no_wen_reading", wen_hi - e0, 0);
    frame_read = 1'b1;
    cyc(10);
    chk("hs_no_wrst_before_vs", wrst_lo - w0, 0);

    // vsync already high when initialized rises: only a fresh rising edge counts.
    initialized = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(10);
    initialized = 1'b1;
    w0 = wrst_lo;
    cyc(40);
    chk("vs_level_no_wrst", wrst_lo - w0, 0);
    vsync = 1'b0;
    cyc(10);
    frame(240, 1'b0);
    wait_nf("vs_level_new_frame");
    chk("vs_level_wrst_low", wrst_lo - w0, WRST_CYCLES);
    handshake("vs_level_ack");

    // Asynchronous reset 100 lines into capture.
    partial(100);
    chk("rst_mid_wen_before", wen, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", wen, 0);
    chk("rst_mid_wrst", wrst, 1);
    chk("rst_mid_new_frame", new_frame, 0);
    @(negedge clk);
    cyc(2);
    rst_n = 1'b1;
    cyc(50);
    chk("rst_mid_no_nf", new_frame, 0);
    w0 = wrst_lo; e0 = wen_hi;
    frame(240, 1'b0);
    wait_nf("rst_after_new_frame");
    chk("rst_after_wrst_low", wrst_lo - w0, WRST_CYCLES);
    chk("rst_after_wen_cycles", wen_hi - e0, 1936);
    chk("rst_after_frame_error", frame_error, 0);
    handshake("rst_after_ack");

    // initialized dropped mid-capture.
    partial(20);
    chk("init_drop_wen_before", wen, 1);
    initialized = 1'b0;
    @(negedge clk);
    chk("init_drop_wen", wen, 0);
    cyc(5);
    vsync = 1'b1; cyc(30);
    vsync = 1'b0; cyc(20);
    chk("init_drop_no_nf", new_frame, 0);
    chk("init_drop_wrst", wrst, 1);
    chk("init_drop_frame_error", frame_error, 0);
    initialized = 1'b1;
    cyc(5);

    chk("wen_guard_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
